// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the RAM-port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;

    localparam logic [1:0] MEMW_B = 2'd0;
    localparam logic [1:0] MEMW_H = 2'd1;
    localparam logic [1:0] MEMW_W = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                rw;
        logic [ADDR_LEN-1:0] addr;
        logic [31:0]         wdata;
        logic [1:0]          typ;
    } ctrl_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the byte-serial RAM engine between instruction fetch and the MEM stage.
// Latency: grant 1 cycle after a request in IDLE, done/valid 1 cycle after ctrl_done.
// Backpressure: requesters hold req until their done pulse; fetch is forced after STARVE_LIMIT data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_signal,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic                if_valid,
    output logic [INST_LEN-1:0] if_data,
    input  logic                mem_req,
    input  logic                mem_rw,
    input  logic [ADDR_LEN-1:0] mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [1:0]          mem_type,
    output logic                mem_done,
    output logic [31:0]         mem_rdata,
    output logic                ctrl_req,
    output logic                ctrl_rw,
    output logic [ADDR_LEN-1:0] ctrl_addr,
    output logic [31:0]         ctrl_wdata,
    output logic [1:0]          ctrl_type,
    output logic                ctrl_abort,
    input  logic                ctrl_done,
    input  logic [31:0]         ctrl_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    ctrl_cmd_t           cmd_q, cmd_d;
    logic                ctrl_req_q, ctrl_req_d;
    logic                ctrl_abort_q, ctrl_abort_d;
    logic                if_valid_q, if_valid_d;
    logic [INST_LEN-1:0] if_data_q, if_data_d;
    logic                mem_done_q, mem_done_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;

    logic fetch_ok;
    logic force_fetch;

    // A redirect in IDLE blocks the fetch grant but leaves data free to go.
    assign fetch_ok    = if_req && !jump_signal;
    assign force_fetch = fetch_ok && (starve_cnt_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        cmd_d        = cmd_q;
        ctrl_req_d   = ctrl_req_q;
        ctrl_abort_d = 1'b0;
        if_valid_d   = 1'b0;
        if_data_d    = if_data_q;
        mem_done_d   = 1'b0;
        mem_rdata_d  = mem_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (mem_req && !force_fetch) begin
                    state_d    = ARB_DATA;
                    ctrl_req_d = 1'b1;
                    cmd_d      = '{rw: mem_rw, addr: mem_addr, wdata: mem_wdata, typ: mem_type};
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CNT_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (fetch_ok) begin
                    state_d      = ARB_FETCH;
                    ctrl_req_d   = 1'b1;
                    cmd_d        = '{rw: 1'b0, addr: if_addr, wdata: '0, typ: MEMW_W};
                    starve_cnt_d = '0;
                end
            end
            ARB_FETCH: begin
                // Data arriving with a jump belongs to the dead path: drop it, no abort needed.
                if (ctrl_done) begin
                    state_d    = ARB_IDLE;
                    ctrl_req_d = 1'b0;
                    if (!jump_signal) begin
                        if_valid_d = 1'b1;
                        if_data_d  = ctrl_rdata;
                    end
                end else if (jump_signal) begin
                    state_d      = ARB_IDLE;
                    ctrl_req_d   = 1'b0;
                    ctrl_abort_d = 1'b1;
                end
            end
            ARB_DATA: begin
                if (ctrl_done) begin
                    state_d    = ARB_IDLE;
                    ctrl_req_d = 1'b0;
                    mem_done_d = 1'b1;
                    if (!cmd_q.rw) begin
                        mem_rdata_d = ctrl_rdata;
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                ctrl_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            cmd_q        <= '0;
            ctrl_req_q   <= 1'b0;
            ctrl_abort_q <= 1'b0;
            if_valid_q   <= 1'b0;
            if_data_q    <= '0;
            mem_done_q   <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cmd_q        <= cmd_d;
            ctrl_req_q   <= ctrl_req_d;
            ctrl_abort_q <= ctrl_abort_d;
            if_valid_q   <= if_valid_d;
            if_data_q    <= if_data_d;
            mem_done_q   <= mem_done_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign ctrl_req   = ctrl_req_q;
    assign ctrl_abort = ctrl_abort_q;
    assign ctrl_rw    = cmd_q.rw;
    assign ctrl_addr  = cmd_q.addr;
    assign ctrl_wdata = cmd_q.wdata;
    assign ctrl_type  = cmd_q.typ;
    assign if_valid   = if_valid_q;
    assign if_data    = if_data_q;
    assign mem_done   = mem_done_q;
    assign mem_rdata  = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level arbiter model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIM = 4;

    logic        clk;
    logic        rst;
    logic        jump_signal;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_type;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        ctrl_req;
    logic        ctrl_rw;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic [1:0]  ctrl_type;
    logic        ctrl_abort;
    logic        ctrl_done;
    logic [31:0] ctrl_rdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .jump_signal(jump_signal),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ctrl_req(ctrl_req), .ctrl_rw(ctrl_rw), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_type(ctrl_type), .ctrl_abort(ctrl_abort), .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] eng_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic idle_inputs();
        jump_signal = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_rw = 1'b0; mem_addr = '0; mem_wdata = '0; mem_type = MEMW_B;
        ctrl_done = 1'b0; ctrl_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({ctrl_req, ctrl_abort, if_valid, mem_done} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {ctrl_req, ctrl_abort, if_valid, mem_done});
        end
        checks++;
        if ({if_data, mem_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h %h want 0 0", if_data, mem_rdata);
        end
        checks++;
        if ({ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_type} !== 67'h0) begin
            errors++; $display("FAIL reset_ctrl_fields: got %b %h %h %b want all 0", ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_type);
        end
        checks++;
        if (dut.state_q !== ARB_IDLE || dut.starve_cnt_q !== 3'd0) begin
            errors++; $display("FAIL reset_state: got state %0d cnt %0d want 0 0", dut.state_q, dut.starve_cnt_q);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lone_fetch();
        int extra_valid = 0;
        if_req = 1'b1; if_addr = 32'h100;
        step();
        checks++;
        if ({ctrl_req, ctrl_rw, ctrl_type, ctrl_addr} !== {1'b1, 1'b0, MEMW_W, 32'h100}) begin
            errors++; $display("FAIL lone_grant: got req %b rw %b type %0d addr %h want 1 0 2 100", ctrl_req, ctrl_rw, ctrl_type, ctrl_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (if_valid) extra_valid++;
        end
        ctrl_done = 1'b1; ctrl_rdata = 32'h0000_0013;
        step();
        ctrl_done = 1'b0; ctrl_rdata = 32'hFFFF_FFFF;
        checks++;
        if ({if_valid, if_data, ctrl_req} !== {1'b1, 32'h13, 1'b0}) begin
            errors++; $display("FAIL lone_valid: got valid %b data %h req %b want 1 00000013 0", if_valid, if_data, ctrl_req);
        end
        if_req = 1'b0;
        step();
        if (if_valid) extra_valid++;
        checks++;
        if (extra_valid != 0) begin
            errors++; $display("FAIL lone_single_pulse: got %0d extra if_valid pulses want 0", extra_valid);
        end
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h140;
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h30004; mem_wdata = 32'hAB; mem_type = MEMW_B;
        step();
        checks++;
        if ({ctrl_req, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_type} !== {1'b1, 1'b1, 32'h30004, 32'hAB, MEMW_B}) begin
            errors++; $display("FAIL contention_data_first: got req %b rw %b addr %h wdata %h type %0d want 1 1 30004 ab 0",
                               ctrl_req, ctrl_rw, ctrl_addr, ctrl_wdata, ctrl_type);
        end
        step(); step();
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        checks++;
        if ({mem_done, if_valid, ctrl_req} !== 3'b100) begin
            errors++; $display("FAIL contention_mem_done: got done %b valid %b req %b want 1 0 0", mem_done, if_valid, ctrl_req);
        end
        mem_req = 1'b0;
        step();
        checks++;
        if ({ctrl_req, ctrl_rw, ctrl_addr} !== {1'b1, 1'b0, 32'h140}) begin
            errors++; $display("FAIL contention_fetch_next: got req %b rw %b addr %h want 1 0 140", ctrl_req, ctrl_rw, ctrl_addr);
        end
        ctrl_done = 1'b1; ctrl_rdata = 32'h0000_0093;
        step();
        ctrl_done = 1'b0;
        if_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int  data_grants = 0;
        bit  fetch_seen = 1'b0;
        bit  last_req = 1'b0;
        bit  pend = 1'b0;
        logic [2:0] cnt_at_fetch = 3'd7;
        if_req = 1'b1; if_addr = 32'h180;
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h44; mem_wdata = 32'h55; mem_type = MEMW_W;
        for (int c = 0; c < 60 && !fetch_seen; c++) begin
            step();
            ctrl_done = 1'b0;
            if (ctrl_req && !last_req) begin
                pend = 1'b1;
                if (ctrl_rw) data_grants++;
                else begin
                    fetch_seen = 1'b1;
                    cnt_at_fetch = dut.starve_cnt_q;
                end
            end
            if (ctrl_req && pend && !fetch_seen) begin
                ctrl_done = 1'b1; pend = 1'b0;
            end
            last_req = ctrl_req;
        end
        checks++;
        if (!fetch_seen || data_grants != LIM) begin
            errors++; $display("FAIL starve_grants: got fetch %b after %0d data grants want fetch after %0d", fetch_seen, data_grants, LIM);
        end
        checks++;
        if (cnt_at_fetch !== 3'd0) begin
            errors++; $display("FAIL starve_cnt_clear: got %0d want 0", cnt_at_fetch);
        end
        ctrl_done = 1'b1; ctrl_rdata = 32'h1234;
        step();
        ctrl_done = 1'b0;
        checks++;
        if ({if_valid, if_data} !== {1'b1, 32'h1234}) begin
            errors++; $display("FAIL starve_fetch_done: got valid %b data %h want 1 00001234", if_valid, if_data);
        end
        if_req = 1'b0; mem_req = 1'b0;
        step();
    endtask

    task automatic test_jump_mid_fetch();
        int aborts = 0;
        int valids = 0;
        if_req = 1'b1; if_addr = 32'h1C0;
        step();
        step(); step();
        jump_signal = 1'b1; if_addr = 32'h200;
        step();
        jump_signal = 1'b0;
        aborts += int'(ctrl_abort); valids += int'(if_valid);
        checks++;
        if ({ctrl_abort, ctrl_req} !== 2'b10) begin
            errors++; $display("FAIL jump_abort: got abort %b req %b want 1 0", ctrl_abort, ctrl_req);
        end
        step();
        aborts += int'(ctrl_abort); valids += int'(if_valid);
        checks++;
        if ({ctrl_req, ctrl_addr} !== {1'b1, 32'h200}) begin
            errors++; $display("FAIL jump_regrant: got req %b addr %h want 1 200", ctrl_req, ctrl_addr);
        end
        checks++;
        if (aborts != 1 || valids != 0) begin
            errors++; $display("FAIL jump_pulse_count: got aborts %0d valids %0d want 1 0", aborts, valids);
        end
        ctrl_done = 1'b1; ctrl_rdata = 32'h0000_0200;
        step();
        ctrl_done = 1'b0;
        if_req = 1'b0;
        step();
    endtask

    task automatic test_jump_with_done();
        if_req = 1'b1; if_addr = 32'h240;
        step(); step();
        jump_signal = 1'b1; ctrl_done = 1'b1; ctrl_rdata = 32'hDEAD_BEEF;
        step();
        jump_signal = 1'b0; ctrl_done = 1'b0; if_req = 1'b0;
        checks++;
        if ({if_valid, ctrl_abort, ctrl_req} !== 3'b000 || dut.state_q !== ARB_IDLE) begin
            errors++; $display("FAIL jump_done_coincide: got valid %b abort %b req %b state %0d want 0 0 0 0",
                               if_valid, ctrl_abort, ctrl_req, dut.state_q);
        end
        step();
        checks++;
        if ({if_valid, ctrl_abort} !== 2'b00) begin
            errors++; $display("FAIL jump_done_late: got valid %b abort %b want 0 0", if_valid, ctrl_abort);
        end
    endtask

    task automatic test_jump_during_store();
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h50; mem_wdata = 32'h1122_3344; mem_type = MEMW_W;
        step();
        jump_signal = 1'b1;
        step();
        checks++;
        if ({ctrl_req, ctrl_abort} !== 2'b10) begin
            errors++; $display("FAIL store_jump_ignored: got req %b abort %b want 1 0", ctrl_req, ctrl_abort);
        end
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0; jump_signal = 1'b0;
        checks++;
        if ({mem_done, ctrl_abort} !== 2'b10) begin
            errors++; $display("FAIL store_completes: got done %b abort %b want 1 0", mem_done, ctrl_abort);
        end
        mem_req = 1'b0;
        step();
    endtask

    task automatic test_reset_in_data();
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h60; mem_type = MEMW_H;
        if_req = 1'b1; if_addr = 32'h280;
        step();
        checks++;
        if ({ctrl_req, ctrl_addr} !== {1'b1, 32'h60}) begin
            errors++; $display("FAIL rst_data_grant: got req %b addr %h want 1 60", ctrl_req, ctrl_addr);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; mem_req = 1'b0;
        checks++;
        if ({ctrl_req, ctrl_abort, if_valid, mem_done, ctrl_rw, ctrl_addr, ctrl_type} !== 39'h0 ||
            dut.state_q !== ARB_IDLE || dut.starve_cnt_q !== 3'd0) begin
            errors++; $display("FAIL rst_in_data: got req %b abort %b addr %h state %0d cnt %0d want all 0",
                               ctrl_req, ctrl_abort, ctrl_addr, dut.state_q, dut.starve_cnt_q);
        end
        step();
        checks++;
        if ({ctrl_req, ctrl_rw, ctrl_addr} !== {1'b1, 1'b0, 32'h280}) begin
            errors++; $display("FAIL rst_then_fetch: got req %b rw %b addr %h want 1 0 280", ctrl_req, ctrl_rw, ctrl_addr);
        end
        ctrl_done = 1'b1; ctrl_rdata = 32'h2800;
        step();
        ctrl_done = 1'b0; if_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] eng_addr = '0;
        int          eng_cnt = 0;
        bit          eng_pend = 1'b0;
        bit          eng_last = 1'b0;
        int          m_starve = 0;
        bit          m_busy = 1'b0;
        bit          m_fetch = 1'b0;
        bit          m_load = 1'b0;
        logic [31:0] m_addr = '0;
        bit          grant, exp_ifv, exp_md, exp_ab;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            // Requesters react to the outputs of the current cycle.
            jump_signal = ($urandom_range(0, 11) == 0);
            if (if_valid || jump_signal) if_req = 1'b0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'h0000_FFFC;
            end
            if (mem_done) mem_req = 1'b0;
            if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req = 1'b1; mem_rw = 1'($urandom_range(0, 1));
                mem_addr = $urandom & 32'h000F_FFFF; mem_wdata = $urandom;
                mem_type = 2'($urandom_range(0, 2));
            end
            if (ctrl_abort) eng_pend = 1'b0;
            if (ctrl_req && !eng_last) begin
                eng_pend = 1'b1; eng_cnt = $urandom_range(0, 3); eng_addr = ctrl_addr;
            end
            eng_last = ctrl_req;
            ctrl_done = 1'b0; ctrl_rdata = $urandom;
            if (eng_pend && ctrl_req) begin
                if (eng_cnt == 0) begin
                    ctrl_done = 1'b1; ctrl_rdata = eng_word(eng_addr); eng_pend = 1'b0;
                end else begin
                    eng_cnt--;
                end
            end
            step();
            // Reference: inputs still hold the values the DUT just sampled.
            grant = 1'b0; exp_ifv = 1'b0; exp_md = 1'b0; exp_ab = 1'b0;
            if (!m_busy) begin
                if (mem_req && !(if_req && !jump_signal && m_starve == LIM)) begin
                    grant = 1'b1; m_fetch = 1'b0; m_load = !mem_rw; m_addr = mem_addr;
                    m_starve = if_req ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
                end else if (if_req && !jump_signal) begin
                    grant = 1'b1; m_fetch = 1'b1; m_addr = if_addr; m_starve = 0;
                end
                m_busy = grant;
            end else if (ctrl_done) begin
                m_busy = 1'b0;
                if (m_fetch) exp_ifv = !jump_signal;
                else exp_md = 1'b1;
            end else if (m_fetch && jump_signal) begin
                m_busy = 1'b0; exp_ab = 1'b1;
            end
            checks++;
            if ({ctrl_req, if_valid, mem_done, ctrl_abort} !== {m_busy, exp_ifv, exp_md, exp_ab}) begin
                errors++; $display("FAIL rnd_handshake cyc %0d: got req/valid/done/abort %b want %b", cyc,
                                   {ctrl_req, if_valid, mem_done, ctrl_abort}, {m_busy, exp_ifv, exp_md, exp_ab});
            end
            if (grant && m_fetch) begin
                checks++;
                if ({ctrl_rw, ctrl_type, ctrl_addr} !== {1'b0, MEMW_W, m_addr}) begin
                    errors++; $display("FAIL rnd_fetch_fields cyc %0d: got rw %b type %0d addr %h want 0 2 %h", cyc, ctrl_rw, ctrl_type, ctrl_addr, m_addr);
                end
            end
            if (grant && !m_fetch) begin
                checks++;
                if ({ctrl_rw, ctrl_type, ctrl_addr, ctrl_wdata} !== {mem_rw, mem_type, mem_addr, mem_wdata}) begin
                    errors++; $display("FAIL rnd_data_fields cyc %0d: got rw %b type %0d addr %h wdata %h want %b %0d %h %h", cyc,
                                       ctrl_rw, ctrl_type, ctrl_addr, ctrl_wdata, mem_rw, mem_type, mem_addr, mem_wdata);
                end
            end
            if (exp_ifv) begin
                checks++;
                if (if_data !== eng_word(m_addr)) begin
                    errors++; $display("FAIL rnd_if_data cyc %0d: got %h want %h", cyc, if_data, eng_word(m_addr));
                end
            end
            if (exp_md && m_load) begin
                checks++;
                if (mem_rdata !== eng_word(m_addr)) begin
                    errors++; $display("FAIL rnd_mem_rdata cyc %0d: got %h want %h", cyc, mem_rdata, eng_word(m_addr));
                end
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_jump_mid_fetch();
        test_jump_with_done();
        test_jump_during_store();
        test_reset_in_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Word-level arbiter and sequencer in front of the byte-serial RAM engine. It shares the single RAM port between two requesters: instruction fetch (from `i_cache`) and the MEM stage (loads and stores). It issues one word request at a time downstream, cancels stale fetches on `jump_signal`, and bounds fetch starvation under back-to-back data traffic.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while a fetch waits before fetch is forced.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset (`ResetEnable`)
- `jump_signal`  in  1  pipeline redirect; kills any pending or in-flight fetch
- `if_req`  in  1  fetch request, held until `if_valid` or a jump
- `if_addr`  in  32  fetch word address
- `if_valid`  out  1  one-cycle pulse: `if_data` valid
- `if_data`  out  32  fetched instruction
- `mem_req`  in  1  data request, held until `mem_done`
- `mem_rw`  in  1  0 = load, 1 = store
- `mem_addr`  in  32  byte address
- `mem_wdata`  in  32  store data, LSB-aligned
- `mem_type`  in  2  access size (`MEMW_B`/`MEMW_H`/`MEMW_W`)
- `mem_done`  out  1  one-cycle pulse: access complete
- `mem_rdata`  out  32  load data, zero-extended; MEM stage sign-extends
- `ctrl_req`  out  1  downstream request, held until `ctrl_done`
- `ctrl_rw`, `ctrl_addr`, `ctrl_wdata`, `ctrl_type`  out  1/32/32/2  registered copy of the granted request
- `ctrl_abort`  out  1  one-cycle pulse: drop the current read
- `ctrl_done`  in  1  one-cycle pulse from the engine
- `ctrl_rdata`  in  32  engine read data, valid with `ctrl_done`

## Operation
- States: IDLE, FETCH, DATA.
- IDLE grant priority:
  - `mem_req` wins, unless `starve_cnt == STARVE_LIMIT` and `if_req` is high; then fetch wins.
  - Otherwise `if_req` (when `jump_signal` is low) goes to FETCH.
  - Granting latches all ctrl_* fields and raises `ctrl_req`.
- `starve_cnt`:
  - Increments on each DATA grant made while `if_req` is high. Saturates at `STARVE_LIMIT`.
  - Clears on a FETCH grant.
  - Clears when a DATA grant is made with `if_req` low.
- FETCH:
  - On `ctrl_done`: capture `ctrl_rdata` into `if_data`, pulse `if_valid`, drop `ctrl_req`, go to IDLE.
  - On `jump_signal` without `ctrl_done`: pulse `ctrl_abort`, drop `ctrl_req`, go to IDLE. No `if_valid` is produced.
  - `jump_signal` and `ctrl_done` in the same cycle: data is discarded, `if_valid` stays low, no abort, go to IDLE.
- DATA:
  - `jump_signal` is ignored; the MEM-stage access is older than the branch and always completes. Stores are never aborted.
  - On `ctrl_done`: for a load, register `ctrl_rdata` into `mem_rdata`; pulse `mem_done` for load and store; go to IDLE.
- IDLE with `jump_signal` high: no fetch grant that cycle. A data grant is still allowed.
- An `if_addr` change while in FETCH without a jump is a requester protocol error and is not required to be handled.

## Timing
- Reset values:
  - State IDLE.
  - `starve_cnt` = 0.
  - All outputs 0: `ctrl_req`, `ctrl_abort`, `if_valid`, `mem_done`, `if_data`, `mem_rdata`, all ctrl_* fields.
- Reset in FETCH or DATA: returns to IDLE next cycle and drops `ctrl_req` with no abort pulse. The engine is reset by the same `rst`.
- Grant latency: request seen in IDLE at cycle N → `ctrl_req` high at N+1.
- Completion latency: `ctrl_done` at cycle M → `if_valid`/`mem_done` pulse at M+1. The state is IDLE at M+1, so a new grant is possible in that same cycle (`ctrl_req` high at M+2).
- Requesters must see their done pulse before deasserting; a held req after done is a new request.
- `ctrl_abort`: pulses at J+1 for a jump at cycle J. The engine must not pulse `ctrl_done` at J+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- `config.vh` gains `MEMW_B = 2'd0`, `MEMW_H = 2'd1`, `MEMW_W = 2'd2`, the state encodings `ARB_IDLE`/`ARB_FETCH`/`ARB_DATA`, and reuses `AddrLen`/`InstLen`/`ResetEnable`.
- Single module, no sub-modules. The starvation counter is inline logic.

## Test plan
- Lone fetch: `if_req` with `if_addr = 0x100`; engine returns `0x00000013` after 5 cycles → `ctrl_addr = 0x100`, `ctrl_type = MEMW_W`, `ctrl_rw = 0`, one `if_valid` pulse with `if_data = 0x00000013`.
- Contention: `if_req` and `mem_req` (store byte `0xAB` at `0x30004`) rise together → data granted first, `ctrl_wdata = 0xAB`, `ctrl_rw = 1`, `mem_done` pulse. Fetch is granted on the cycle of `mem_done`.
- Starvation: `mem_req` held continuously with `if_req` high, `STARVE_LIMIT = 4` → exactly 4 data grants, then a fetch grant, then `starve_cnt` reads 0.
- Jump mid-fetch: jump 2 cycles after the fetch grant → `ctrl_abort` pulses once, no `if_valid`. A new `if_addr = 0x200` is granted next cycle.
- Jump coincident with `ctrl_done` in FETCH, and separately jump during a DATA store → first case: no `if_valid` and no abort. Second case: store completes with `mem_done`, no abort.
- Reset asserted in DATA → the next cycle shows all outputs 0 and state IDLE. A pending `if_req` is then granted normally.
